// File: rtl/matmul_row_sequencer_if.sv
// ============================================================================
//  Module   : matmul_row_sequencer_if
//  Brief    : A-row fetch, datapath and result-row bus of the matmul sequencer
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface matmul_row_sequencer_if #(
  parameter int A_ROWS = 4,
  parameter int N      = 4,
  parameter int B_COLS = 4,
  parameter int DW     = 20,
  parameter int PW     = 40
);
  localparam int AW = (A_ROWS > 1) ? $clog2(A_ROWS) : 1;

  logic                   a_req;
  logic [AW-1:0]          a_addr;
  logic                   a_valid;
  logic [N*DW-1:0]        a_data;
  logic [N*DW-1:0]        dp_vec;
  logic [B_COLS*PW-1:0]   dp_res;
  logic                   r_valid;
  logic                   r_ready;
  logic [AW-1:0]          r_addr;
  logic [B_COLS*PW-1:0]   r_data;

  modport master (
    output a_req, a_addr, dp_vec, r_valid, r_addr, r_data,
    input  a_valid, a_data, dp_res, r_ready
  );

  modport slave (
    input  a_req, a_addr, dp_vec, r_valid, r_addr, r_data,
    output a_valid, a_data, dp_res, r_ready
  );
endinterface

`default_nettype wire

// File: rtl/matmul_row_sequencer.sv
// ============================================================================
//  Module   : matmul_row_sequencer
//  Brief    : Runs A x B one row at a time through a combinational vector x
//             matrix datapath. Optional MATSEQ_CYCLE_CNT_EN adds cycle_cnt.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module matmul_row_sequencer #(
  parameter int A_ROWS     = 4,
  parameter int N          = 4,
  parameter int B_COLS     = 4,
  parameter int DW         = 20,
  parameter int PW         = 40,
  parameter int SETTLE_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  matmul_row_sequencer_if.master bus
`ifdef MATSEQ_CYCLE_CNT_EN
  ,
  output logic [31:0]            cycle_cnt
`endif
);

  localparam int AW = (A_ROWS > 1) ? $clog2(A_ROWS) : 1;
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [AW-1:0] LAST_ROW   = AW'(A_ROWS - 1);
  localparam logic [CW-1:0] SETTLE_INI = CW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_SETTLE = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        state;
  logic [AW-1:0] row;
  logic [CW-1:0] settle_cnt;

  // a_addr only moves when a new FETCH is entered, so it is stable while a_req
  assign bus.a_addr = row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      row         <= '0;
      settle_cnt  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bus.a_req   <= 1'b0;
      bus.r_valid <= 1'b0;
      bus.r_addr  <= '0;
      bus.dp_vec  <= '0;
      bus.r_data  <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Datapath vector and last result row are deliberately left intact
        state       <= S_IDLE;
        row         <= '0;
        busy        <= 1'b0;
        bus.a_req   <= 1'b0;
        bus.r_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state     <= S_FETCH;
              row       <= '0;
              busy      <= 1'b1;
              bus.a_req <= 1'b1;
            end
          end
          S_FETCH: begin
            if (bus.a_valid) begin
              bus.dp_vec <= bus.a_data;
              settle_cnt <= SETTLE_INI;
              bus.a_req  <= 1'b0;
              state      <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (settle_cnt == '0) begin
              bus.r_data  <= bus.dp_res;
              bus.r_addr  <= row;
              bus.r_valid <= 1'b1;
              state       <= S_WRITE;
            end else begin
              settle_cnt <= settle_cnt - 1'b1;
            end
          end
          S_WRITE: begin
            if (bus.r_ready) begin
              bus.r_valid <= 1'b0;
              if (row == LAST_ROW) begin
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                row       <= row + 1'b1;
                bus.a_req <= 1'b1;
                state     <= S_FETCH;
              end
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            bus.a_req   <= 1'b0;
            bus.r_valid <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef MATSEQ_CYCLE_CNT_EN
  // Counts every busy cycle of the current run and freezes once idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
    end else if (state == S_IDLE && start && !abort) begin
      cycle_cnt <= '0;
    end else if (busy && cycle_cnt != 32'hFFFF_FFFF) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_matmul_row_sequencer.sv
// ============================================================================
//  Module   : tb_matmul_row_sequencer
//  Brief    : Scoreboard bench for matmul_row_sequencer with a registered
//             datapath model; honours MATSEQ_CYCLE_CNT_EN when defined.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_matmul_row_sequencer;
  localparam int A_ROWS = 4, N = 4, B_COLS = 4, DW = 20, PW = 40, SETTLE_CYC = 2;
  localparam int VW = N * DW;
  localparam int RW = B_COLS * PW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done;
`ifdef MATSEQ_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;
`endif

  matmul_row_sequencer_if #(.A_ROWS(A_ROWS), .N(N), .B_COLS(B_COLS), .DW(DW), .PW(PW)) bus ();

  matmul_row_sequencer #(
    .A_ROWS(A_ROWS), .N(N), .B_COLS(B_COLS), .DW(DW), .PW(PW), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
`ifdef MATSEQ_CYCLE_CNT_EN
    ,
    .cycle_cnt (cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  // A row buffer and a datapath whose result lags dp_vec by one edge
  logic [VW-1:0] a_mem [A_ROWS];
  logic [RW-1:0] dp_res_q = '0;
  assign bus.a_data = a_mem[bus.a_addr];
  assign bus.dp_res = dp_res_q;

  function automatic logic [RW-1:0] dp_f(input logic [VW-1:0] v);
    logic [RW-1:0] r;
    logic [PW-1:0] s;
    r = '0;
    for (int j = 0; j < B_COLS; j++) begin
      s = '0;
      for (int k = 0; k < N; k++)
        s += PW'(v[k*DW +: DW]) * PW'(k * B_COLS + j + 1);
      r[j*PW +: PW] = s;
    end
    return r;
  endfunction

  always @(posedge clk) dp_res_q <= dp_f(bus.dp_vec);

  typedef struct {
    logic [1:0]    addr;
    logic [RW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  int n_pass = 0;
  int n_total = 0;
  int done_cnt = 0;
  bit in_reset = 1'b1;
  int bp_row = -1, bp_left = 0, st_row = -1, st_left = 0;
  bit bp_active = 1'b0, st_active = 1'b0;
  logic [RW-1:0] bp_exp = '0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  task automatic push_row(input int addr, input logic [PW-1:0] c0, input logic [PW-1:0] c1,
                          input logic [PW-1:0] c2, input logic [PW-1:0] c3);
    exp_t e;
    e.addr = 2'(addr);
    e.data = {c3, c2, c1, c0};
    exp_q.push_back(e);
  endtask

  task automatic load_identity();
    for (int i = 0; i < A_ROWS; i++) begin
      a_mem[i] = '0;
      a_mem[i][i*DW +: DW] = 20'd1;
    end
  endtask

  // Drives a_valid/r_ready (with optional stalls) and scores each result handshake
  always @(negedge clk) begin
    if (!in_reset) begin
      if (done) done_cnt++;
      if (st_left > 0 && (st_active || (bus.a_req && int'(bus.a_addr) == st_row))) begin
        st_active = 1'b1;
        bus.a_valid = 1'b0;
        chk("stall_a_req", RW'(bus.a_req), RW'(1));
        chk("stall_a_addr", RW'(bus.a_addr), RW'(st_row));
        chk("stall_dp_vec", RW'(bus.dp_vec), RW'(a_mem[st_row-1]));
        st_left--;
      end else begin
        bus.a_valid = 1'b1;
      end
      if (bp_left > 0 && (bp_active || (bus.r_valid && int'(bus.r_addr) == bp_row))) begin
        bp_active = 1'b1;
        bus.r_ready = 1'b0;
        chk("bp_r_valid", RW'(bus.r_valid), RW'(1));
        chk("bp_r_addr", RW'(bus.r_addr), RW'(bp_row));
        chk("bp_r_data", bus.r_data, bp_exp);
        chk("bp_no_fetch", RW'(bus.a_req), RW'(0));
        bp_left--;
      end else begin
        bus.r_ready = 1'b1;
      end
      if (bus.r_valid && bus.r_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_row: got row %0d expected none", bus.r_addr);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("row_addr", RW'(bus.r_addr), RW'(e.addr));
          chk("row_data", bus.r_data, e.data);
        end
      end
    end
  end

  task automatic run(input int exp_cyc, input bit hold);
    int n;
    int d0;
    bit seen;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("first_fetch", RW'({bus.a_req, bus.a_addr}), RW'(3'b100));
      if (done) seen = 1'b1;
    end
    chk("done_latency", RW'(n), RW'(exp_cyc));
    if (hold) begin
      @(posedge clk);
      #1 start = 1'b0;
    end
    @(negedge clk);
    chk("done_one_cycle", RW'(done), RW'(0));
    chk("idle_after_done", RW'(busy), RW'(0));
`ifdef MATSEQ_CYCLE_CNT_EN
    chk("cycle_cnt", RW'(cycle_cnt), RW'(exp_cyc));
`endif
    chk("rows_left", RW'(exp_q.size()), RW'(0));
    chk("done_pulses", RW'(done_cnt - d0), RW'(1));
  endtask

  initial begin
    int d0;
    load_identity();
    bus.a_valid = 1'b0;
    bus.r_ready = 1'b0;

    // Reset with random control inputs
    repeat (5) begin
      @(negedge clk);
      start = 1'($urandom);
      abort = 1'($urandom);
      bus.a_valid = 1'($urandom);
      bus.r_ready = 1'($urandom);
      chk("reset_ctrl", RW'({busy, done, bus.a_req, bus.r_valid}), RW'(0));
      chk("reset_addr", RW'({bus.a_addr, bus.r_addr}), RW'(0));
      chk("reset_dp_vec", RW'(bus.dp_vec), RW'(0));
      chk("reset_r_data", bus.r_data, RW'(0));
`ifdef MATSEQ_CYCLE_CNT_EN
      chk("reset_cycle_cnt", RW'(cycle_cnt), RW'(0));
`endif
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    rst_n = 1'b1;
    in_reset = 1'b0;
    @(negedge clk);
    chk("no_start_latched", RW'({busy, bus.a_req}), RW'(0));

    // Identity A: each result row equals the matching B row
    for (int i = 0; i < A_ROWS; i++)
      push_row(i, PW'(4*i+1), PW'(4*i+2), PW'(4*i+3), PW'(4*i+4));
    run(17, 1'b0);

    // Mixed rows with result backpressure on row 1 and a fetch stall on row 2
    a_mem[0] = '0; a_mem[0][0 +: DW] = 20'd1;
    a_mem[1] = {20'd1, 20'd1, 20'd1, 20'd1};
    a_mem[2] = '0; a_mem[2][0 +: DW] = 20'hFFFFF;
    a_mem[3] = '0; a_mem[3][3*DW +: DW] = 20'd3;
    push_row(0, 40'd1, 40'd2, 40'd3, 40'd4);
    push_row(1, 40'd28, 40'd32, 40'd36, 40'd40);
    push_row(2, 40'hFFFFF, 40'h1FFFFE, 40'h2FFFFD, 40'h3FFFFC);
    push_row(3, 40'd39, 40'd42, 40'd45, 40'd48);
    bp_exp = {40'd40, 40'd36, 40'd32, 40'd28};
    bp_active = 1'b0; bp_row = 1; bp_left = 5;
    st_active = 1'b0; st_row = 2; st_left = 3;
    run(25, 1'b0);
    chk("bp_consumed", RW'(bp_left), RW'(0));
    chk("stall_consumed", RW'(st_left), RW'(0));

    // Abort during SETTLE of row 1
    load_identity();
    push_row(0, 40'd1, 40'd2, 40'd3, 40'd4);
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_idle", RW'({busy, done, bus.a_req, bus.r_valid}), RW'(0));
    repeat (5) @(negedge clk);
    chk("abort_no_done", RW'(done_cnt - d0), RW'(0));
    chk("abort_rows", RW'(exp_q.size()), RW'(0));
    chk("abort_dp_vec_kept", RW'(bus.dp_vec), RW'(a_mem[1]));
    for (int i = 0; i < A_ROWS; i++)
      push_row(i, PW'(4*i+1), PW'(4*i+2), PW'(4*i+3), PW'(4*i+4));
    run(17, 1'b0);

    // start held high through the whole run and the DONE cycle
    for (int i = 0; i < A_ROWS; i++)
      push_row(i, PW'(4*i+1), PW'(4*i+2), PW'(4*i+3), PW'(4*i+4));
    d0 = done_cnt;
    run(17, 1'b1);
    repeat (10) @(negedge clk);
    chk("no_extra_run", RW'({busy, bus.a_req}), RW'(0));
    chk("single_done", RW'(done_cnt - d0), RW'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit expected finish");
    $fatal(1);
  end
endmodule

`default_nettype wire
